// File: rtl/audio_pkg.sv
// Shared constants for the audio path: I2S frame geometry and word-select polarity.
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_BITS  = 16;
  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef logic [CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider; tick marks the clk cycle in which bclk falls.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 24
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic tick
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             terminal;

  assign terminal = (div_cnt_reg == DIV_W'(BCLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else if (terminal) begin
      div_cnt_reg <= '0;
      bclk_reg    <= ~bclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign bclk = bclk_reg;
  assign tick = terminal & bclk_reg;

endmodule

// File: rtl/i2s_sample_tx.sv
// Requests one mono sample per frame, captures it, and serializes it to the DAC
// as I2S with the same word in both the left and right slots.
module i2s_sample_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 24,
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                sampling_pulse,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                underrun
);

  localparam int WORD_W = 2 * SAMPLE_W;

  logic                tick;
  bit_cnt_t            bit_cnt_reg;
  bit_cnt_t            bit_cnt_next;
  logic [WORD_W-1:0]   shreg_reg;
  logic [WORD_W-1:0]   frame_word;
  logic [SAMPLE_W-1:0] hold_reg;
  logic                got_sample_reg;
  logic                frame_start_reg;
  logic                lrck_reg;
  logic                sdata_reg;
  logic                sampling_pulse_reg;
  logic                underrun_reg;
  logic                frame_tick;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk   (clk),
    .reset (reset),
    .bclk  (bclk),
    .tick  (tick)
  );

  // Mono source: the held sample fills every slot of the frame.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign frame_word[gi*SAMPLE_W +: SAMPLE_W] = hold_reg;
  end

  assign bit_cnt_next = bit_cnt_reg + 1'b1;
  assign frame_tick   = tick && (bit_cnt_next == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg <= '1;
      shreg_reg   <= '0;
      sdata_reg   <= 1'b0;
      lrck_reg    <= RIGHT;
    end else if (tick) begin
      bit_cnt_reg <= bit_cnt_next;
      // sdata lags shreg by one bclk, giving the I2S one-bit delay after lrck
      sdata_reg   <= shreg_reg[WORD_W-1];
      if (bit_cnt_next == '0) begin
        shreg_reg <= frame_word;
        lrck_reg  <= LEFT;
      end else begin
        shreg_reg <= shreg_reg << 1;
        if (bit_cnt_next == bit_cnt_t'(SLOT_BITS)) begin
          lrck_reg <= RIGHT;
        end
      end
    end
  end

  // Request and underrun bookkeeping run one clk after the frame-start tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start_reg    <= 1'b0;
      sampling_pulse_reg <= 1'b0;
      underrun_reg       <= 1'b0;
      hold_reg           <= '0;
      got_sample_reg     <= 1'b0;
    end else begin
      frame_start_reg    <= frame_tick;
      sampling_pulse_reg <= frame_start_reg;
      underrun_reg       <= frame_start_reg & ~got_sample_reg;
      // A strobe coinciding with the clear belongs to the new frame
      if (sample_ready) begin
        hold_reg       <= sample;
        got_sample_reg <= 1'b1;
      end else if (frame_start_reg) begin
        got_sample_reg <= 1'b0;
      end
    end
  end

  assign sampling_pulse = sampling_pulse_reg;
  assign lrck           = lrck_reg;
  assign sdata          = sdata_reg;
  assign underrun       = underrun_reg;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed bench for i2s_sample_tx with BCLK_DIV=2 (128 clk per frame).
module tb_i2s_sample_tx;

  localparam int BCLK_DIV = 2;
  localparam int FRAME_CLK = 64 * BCLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_ready = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        sampling_pulse;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  i2s_sample_tx #(.BCLK_DIV(BCLK_DIV), .SAMPLE_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_ready   (sample_ready),
    .sample         (sample),
    .sampling_pulse (sampling_pulse),
    .bclk           (bclk),
    .lrck           (lrck),
    .sdata          (sdata),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  // Receiver: deserializes each complete frame on bclk falling edges.
  int          frame_cnt = 0;
  int          pulse_cnt = 0;
  int          underrun_cnt = 0;
  int          m_low = 0;
  int          last_low = 0;
  logic        m_valid = 1'b0;
  logic        m_bclk_q = 1'b0;
  logic        m_lr_q = 1'b1;
  logic [31:0] m_word = 32'h0;
  logic [15:0] last_left = 16'h0;
  logic [15:0] last_right = 16'h0;
  logic [31:0] rx_q[$];

  always @(posedge clk) begin
    #1;
    if (reset) begin
      m_valid  = 1'b0;
      m_bclk_q = 1'b0;
      m_lr_q   = 1'b1;
      m_low    = 0;
    end else begin
      if (sampling_pulse) pulse_cnt++;
      if (underrun) underrun_cnt++;
      if (m_bclk_q && !bclk) begin
        m_word = {m_word[30:0], sdata};
        if (!lrck && m_lr_q) begin
          if (m_valid) begin
            last_left  = m_word[31:16];
            last_right = m_word[15:0];
            last_low   = m_low;
            rx_q.push_back(m_word);
          end
          m_valid = 1'b1;
          m_low   = 1;
          frame_cnt++;
        end else if (!lrck) begin
          m_low++;
        end
        m_lr_q = lrck;
      end
      m_bclk_q = bclk;
    end
  end

  // Sample source: answers each pulse 3 clk later (mode 1/2/3), or strobes during reset.
  int          resp_mode = 0;
  logic [15:0] resp_w1 = 16'h0;
  logic [15:0] resp_w2 = 16'h0;
  logic        late_strobe = 1'b0;
  int          r_cnt = 0;
  int          dds_n = 0;
  logic [21:0] dds_phase = 22'h0;
  logic [21:0] dds_step = {12'd58, 10'd360};
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (reset) begin
      r_cnt        = 0;
      sample_ready = late_strobe;
      sample       = 16'hBEEF;
    end else begin
      sample_ready = 1'b0;
      if (resp_mode != 0 && sampling_pulse) r_cnt = 1;
      else if (r_cnt != 0 && r_cnt < 20) r_cnt++;
      else r_cnt = 0;
      if (r_cnt == 3 && resp_mode != 0) begin
        sample_ready = 1'b1;
        if (resp_mode == 3) begin
          dds_phase = dds_phase + dds_step;
          sample    = dds_phase[21:6];
          exp_q.push_back(sample);
          dds_n++;
          if (dds_n == 125) dds_step = {12'd98, 10'd68};
        end else begin
          sample = resp_w1;
        end
      end
      if (r_cnt == 10 && resp_mode == 2) begin
        sample_ready = 1'b1;
        sample       = resp_w2;
      end
    end
  end

  task automatic wait_frames(input int n, input string tag);
    int target = frame_cnt + n;
    int budget = n * FRAME_CLK + 64;
    while (frame_cnt < target && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    tests++;
    if (frame_cnt < target) begin
      fails++;
      $display("FAIL %s frame wait: got %0d frames, required %0d", tag, frame_cnt, target);
    end
  endtask

  task automatic test_reset(input string tag);
    logic eb, el, ep;
    tests += 5;
    if (bclk !== 1'b0)           begin fails++; $display("FAIL %s rst bclk: got %b want 0", tag, bclk); end
    if (lrck !== 1'b1)           begin fails++; $display("FAIL %s rst lrck: got %b want 1", tag, lrck); end
    if (sdata !== 1'b0)          begin fails++; $display("FAIL %s rst sdata: got %b want 0", tag, sdata); end
    if (sampling_pulse !== 1'b0) begin fails++; $display("FAIL %s rst pulse: got %b want 0", tag, sampling_pulse); end
    if (underrun !== 1'b0)       begin fails++; $display("FAIL %s rst underrun: got %b want 0", tag, underrun); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      eb = (k == 2 || k == 3 || k == 6);
      el = (k < 4);
      ep = (k == 5);
      tests += 5;
      if (bclk !== eb)           begin fails++; $display("FAIL %s t0+%0d bclk: got %b want %b", tag, k, bclk, eb); end
      if (lrck !== el)           begin fails++; $display("FAIL %s t0+%0d lrck: got %b want %b", tag, k, lrck, el); end
      if (sdata !== 1'b0)        begin fails++; $display("FAIL %s t0+%0d sdata: got %b want 0", tag, k, sdata); end
      if (sampling_pulse !== ep) begin fails++; $display("FAIL %s t0+%0d pulse: got %b want %b", tag, k, sampling_pulse, ep); end
      if (underrun !== ep)       begin fails++; $display("FAIL %s t0+%0d underrun: got %b want %b", tag, k, underrun, ep); end
    end
    $display("[TB] %s: reset release sequence checked", tag);
  endtask

  task automatic test_stream();
    int u0, p0;
    resp_w1   = 16'hA5C3;
    resp_mode = 1;
    wait_frames(1, "stream");
    repeat (2) @(posedge clk);
    #2;
    u0 = underrun_cnt;
    p0 = pulse_cnt;
    wait_frames(2, "stream");
    tests += 5;
    if (last_left !== 16'hA5C3)  begin fails++; $display("FAIL stream left: got %h want a5c3", last_left); end
    if (last_right !== 16'hA5C3) begin fails++; $display("FAIL stream right: got %h want a5c3", last_right); end
    if (last_low != 16)          begin fails++; $display("FAIL stream lrck low ticks: got %0d want 16", last_low); end
    if (underrun_cnt != u0)      begin fails++; $display("FAIL stream underrun: got %0d want %0d", underrun_cnt, u0); end
    if (pulse_cnt != p0 + 1)     begin fails++; $display("FAIL stream pulses: got %0d want %0d", pulse_cnt, p0 + 1); end
    $display("[TB] stream: left=%h right=%h", last_left, last_right);
  endtask

  task automatic test_underrun();
    int u0;
    resp_w1 = 16'h7FFF;
    wait_frames(1, "underrun");
    resp_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    u0 = underrun_cnt;
    wait_frames(1, "underrun");
    resp_w1   = 16'h1111;
    resp_mode = 1;
    wait_frames(1, "underrun");
    tests += 3;
    if (underrun_cnt != u0 + 1)  begin fails++; $display("FAIL underrun count: got %0d want %0d", underrun_cnt - u0, 1); end
    if (last_left !== 16'h7FFF)  begin fails++; $display("FAIL underrun repeat left: got %h want 7fff", last_left); end
    if (last_right !== 16'h7FFF) begin fails++; $display("FAIL underrun repeat right: got %h want 7fff", last_right); end
    $display("[TB] underrun: repeated left=%h right=%h", last_left, last_right);
  endtask

  task automatic test_double_strobe();
    int u0;
    resp_w1   = 16'h1234;
    resp_w2   = 16'h8001;
    resp_mode = 2;
    repeat (2) @(posedge clk);
    #2;
    u0 = underrun_cnt;
    wait_frames(2, "double");
    tests += 4;
    if (last_left !== 16'h8001)  begin fails++; $display("FAIL double left: got %h want 8001", last_left); end
    if (last_right !== 16'h8001) begin fails++; $display("FAIL double right: got %h want 8001", last_right); end
    if (last_left[15] !== 1'b1)  begin fails++; $display("FAIL double msb: got %b want 1", last_left[15]); end
    if (underrun_cnt != u0)      begin fails++; $display("FAIL double underrun: got %0d want %0d", underrun_cnt, u0); end
    resp_w1   = 16'hFFFF;
    resp_mode = 1;
    $display("[TB] double strobe: left=%h right=%h", last_left, last_right);
  endtask

  task automatic test_reset_mid_frame();
    int   n = 0;
    int   budget = 200;
    logic prev;
    wait_frames(1, "midrst");
    prev = bclk;
    while (n < 9 && budget > 0) begin
      @(posedge clk);
      #1;
      if (prev && !bclk) n++;
      prev = bclk;
      budget--;
    end
    tests += 2;
    if (n != 9)         begin fails++; $display("FAIL midrst tick count: got %0d want 9", n); end
    if (sdata !== 1'b1) begin fails++; $display("FAIL midrst sdata before reset: got %b want 1", sdata); end
    resp_mode   = 0;
    late_strobe = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    tests += 2;
    if (sdata !== 1'b0) begin fails++; $display("FAIL midrst async sdata: got %b want 0", sdata); end
    if (lrck !== 1'b1)  begin fails++; $display("FAIL midrst async lrck: got %b want 1", lrck); end
    repeat (3) @(posedge clk);
    late_strobe = 1'b0;
    @(posedge clk);
    #2;
    test_reset("midrst");
    wait_frames(1, "midrst");
    tests += 2;
    if (last_left !== 16'h0000)  begin fails++; $display("FAIL midrst hold left: got %h want 0000", last_left); end
    if (last_right !== 16'h0000) begin fails++; $display("FAIL midrst hold right: got %h want 0000", last_right); end
    $display("[TB] mid-frame reset: first frame left=%h right=%h", last_left, last_right);
  endtask

  task automatic test_sample_source();
    int          u0, p0;
    logic [31:0] w;
    logic [15:0] e;
    resp_mode = 3;
    wait_frames(1, "source");
    rx_q.delete();
    u0 = underrun_cnt;
    p0 = pulse_cnt;
    for (int i = 0; i < 250; i++) begin
      wait_frames(1, "source");
      tests++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL source frame %0d: rx %0d exp %0d queued", i, rx_q.size(), exp_q.size());
      end else begin
        w = rx_q.pop_front();
        e = exp_q.pop_front();
        if (w !== {e, e}) begin
          fails++;
          $display("FAIL source frame %0d: got %h/%h want %h/%h", i, w[31:16], w[15:0], e, e);
        end
      end
    end
    resp_mode = 0;
    tests += 2;
    if (underrun_cnt != u0)    begin fails++; $display("FAIL source underrun: got %0d want 0", underrun_cnt - u0); end
    if (pulse_cnt != p0 + 250) begin fails++; $display("FAIL source pulses: got %0d want 250", pulse_cnt - p0); end
    $display("[TB] sample source: 250 frames compared");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    test_reset("reset");
    test_stream();
    test_underrun();
    test_double_strobe();
    test_reset_mid_frame();
    test_sample_source();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
- Audio-side consumer of the DDS sample interface.
- Generates the per-frame sampling_pulse request and captures the returned 16-bit sample on sample_ready.
- Serializes the captured sample as a standard I2S stream to the board DAC; the same mono sample goes out on left and right.
- Sits between the dds block and the DAC pins, and is the frame-rate master of the audio path.

Parameters:
- BCLK_DIV, 24, clk cycles per half-period of bclk (must be at least 2). Frame = 64*BCLK_DIV clk; 100 MHz clk gives fs ≈ 65.1 kHz.
- SAMPLE_W, 16, sample width in bits; fixed at 16 in this revision.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_ready  input  1  one-clk strobe from the sample source; sample is valid in this cycle.
- sample  input  16  signed two's-complement sample.
- sampling_pulse  output  1  one-clk request to the source for the next sample.
- bclk  output  1  I2S bit clock.
- lrck  output  1  I2S word select; 0 = left, 1 = right.
- sdata  output  1  I2S serial data, MSB first.
- underrun  output  1  one-clk flag: a frame started with no new sample captured.

Behaviour:
- Reset values (asynchronous):
  - bclk=0, lrck=1, sdata=0, sampling_pulse=0, underrun=0.
  - hold=0, shreg=0, bit_cnt=31, div_cnt=0, got_sample=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1; at the terminal count bclk toggles and div_cnt returns to 0.
  - A "tick" is the clk cycle in which bclk toggles 1->0.
  - First tick falls 2*BCLK_DIV clk after reset release.
- On each tick:
  - bit_cnt increments mod 32.
  - sdata <= shreg[31].
  - If the new bit_cnt is 0, shreg <= {hold,hold}; otherwise shreg <= shreg<<1.
  - This gives the standard I2S one-bclk delay: the MSB appears on the tick after the lrck change.
- lrck:
  - Goes 0 on the tick where the new bit_cnt is 0.
  - Goes 1 on the tick where the new bit_cnt is 16.
- Frame start is the tick where the new bit_cnt is 0. In the following clk cycle:
  - sampling_pulse=1 for exactly one clk.
  - underrun=1 if got_sample==0.
  - got_sample is cleared.
- Capture:
  - Any clk with sample_ready=1 loads hold<=sample and sets got_sample=1.
  - Multiple strobes in one frame: the last one wins.
  - A strobe in the same clk as the got_sample clear counts for the new frame, so set wins over clear.
- Latency: a sample returned after the pulse of frame N is loaded at the start of frame N+1. Its MSB appears on sdata at the second tick of frame N+1.
- Underrun: hold is retained, so the previous sample repeats; no other recovery action.
- Reset mid-frame: everything returns immediately to reset values. A partial word is abandoned and a late sample_ready is ignored while reset=1.
- No handshake back-pressure. The source must answer within one frame.

Decomposition:
- audio_pkg holds SAMPLE_W=16, SLOT_BITS=16 and FRAME_BITS=32, plus the lrck polarity constants LEFT=0 and RIGHT=1.
- One natural sub-module, i2s_bclk_gen: div_cnt, bclk and the tick output, parameterized by BCLK_DIV.
- The shifter, frame control and capture logic stay in i2s_sample_tx.

Test Plan (BCLK_DIV=2, frame=128 clk):
1. Release reset at t0 with no activity -> bclk=0, lrck=1, sdata=0 until first tick at t0+4. sampling_pulse high exactly at t0+5 for one clk; underrun=1 at t0+5 (nothing captured yet).
2. Answer each pulse 3 clk later with sample_ready, sample=16'hA5C3 -> next frame: lrck=0 for 16 ticks, then sdata shows 1010_0101_1100_0011 starting on the second tick. The same 16 bits follow lrck=1; underrun stays 0.
3. Stop answering for one frame after 16'h7FFF was sent -> underrun pulses one clk at the next frame start; sdata repeats 16'h7FFF in both slots.
4. Two strobes in one frame, 16'h1234 then 16'h8001 -> only 16'h8001 is transmitted next frame; the first MSB bit is 1.
5. Assert reset at bit_cnt=9 of a frame carrying 16'hFFFF -> sdata=0 and lrck=1 immediately. After release the sequence matches scenario 1 exactly.
6. Connect to dds with k={12'd58,10'd360}, then switch to {12'd98,10'd68} -> one sampling_pulse per frame and no underrun. Deserialized left word equals the sample captured one frame earlier and equals the right word, for 250 frames.
